btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Per-button input conditioner for the pong top level. Sits upstream of the game/VGA controller; replaces the bare 2-FF stretchers on up/down/pause.
- Per channel: synchronises a raw pushbutton pin, debounces it with a stability counter, and produces four outputs:
  - clean level
  - single-cycle press pulse
  - single-cycle release pulse
  - auto-repeat step pulse, so a held up/down button moves the paddle at a fixed rate.

Parameters:
- NUM_BTN, 3, number of independent button channels (1..8).
- DB_CYCLES, 1000000, consecutive stable samples required to accept a new level (10 ms at 100 MHz); must be >= 2.
- RPT_DELAY, 50000000, cycles from the press pulse to the first repeat pulse (0.5 s).
- RPT_PERIOD, 10000000, cycles between subsequent repeat pulses (0.1 s).
- RPT_MASK, 3'b011, bit i = 1 enables auto-repeat on channel i.

Ports:
- clk  in  1  master clock, 100 MHz
- rst  in  1  asynchronous reset, active-high
- btn_in  in  NUM_BTN  raw pushbutton pins, active-high, asynchronous to clk
- btn_level  out  NUM_BTN  debounced button level
- btn_press  out  NUM_BTN  one-cycle pulse on accepted rising edge
- btn_release  out  NUM_BTN  one-cycle pulse on accepted falling edge
- btn_step  out  NUM_BTN  one-cycle pulse: press pulse OR auto-repeat pulse (gated by RPT_MASK)

Behaviour:
- Reset (asynchronous assert, synchronous release via clk): sync FFs, level, counters, all outputs = 0; every channel FSM = IDLE.
- Synchroniser: 2 FFs per channel; s2 is the only signal used downstream.
- Per-channel FSM states:
  - IDLE: level 0, stable.
  - PRESS_WAIT: s2 = 1, counting.
  - HELD: level 1.
  - RELEASE_WAIT: s2 = 0, counting.
- Transitions:
  - IDLE → PRESS_WAIT when s2 = 1; db_cnt = 1.
  - PRESS_WAIT:
    - s2 = 0 → IDLE, db_cnt = 0.
    - s2 = 1 and db_cnt = DB_CYCLES-1 → HELD; assert btn_press and btn_step for that cycle; level ← 1; rpt_cnt = 0.
    - otherwise db_cnt++.
  - HELD → RELEASE_WAIT when s2 = 0; db_cnt = 1.
  - RELEASE_WAIT:
    - s2 = 1 → HELD; db_cnt = 0; rpt_cnt keeps running, with no restart and no pulse.
    - s2 = 0 and db_cnt = DB_CYCLES-1 → IDLE; assert btn_release; level ← 0.
    - otherwise db_cnt++.
- Latency: if the pin value changes so that edge E0 is the first clk edge sampling it into sync FF1, outputs change after edge E0+DB_CYCLES+1 (visible in cycle E0+DB_CYCLES+2). The pin must stay stable for that whole time.
- Glitch rejection: any opposite s2 sample during a WAIT state fully resets the count. A pulse shorter than DB_CYCLES s2 samples produces no output.
- Auto-repeat (channel enabled in RPT_MASK, state HELD or RELEASE_WAIT):
  - rpt_cnt counts cycles since the press pulse.
  - First btn_step pulse at RPT_DELAY cycles after the press pulse.
  - Then one pulse every RPT_PERIOD cycles.
  - Counter saturates/reloads; no wrap glitch.
  - Stops immediately on entering IDLE.
  - Disabled channels: btn_step == btn_press.
- Mutual exclusion: btn_press and btn_release never both high on one channel. A repeat pulse never coincides with btn_press.
- Channels are fully independent; simultaneous presses on several channels produce same-cycle pulses on each.
- Reset mid-operation: counters clear. A button held through reset deassertion goes through the full debounce again and yields exactly one btn_press.
- Counter widths: db_cnt = clog2(DB_CYCLES); rpt_cnt = clog2(max(RPT_DELAY, RPT_PERIOD)+1). All comparisons are unsigned.
- All outputs are registered (no combinational path from btn_in).

Decomposition:
- Shared package btn_pkg: FSM state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3) and default timing constants for 100 MHz.
- Sub-module btn_debounce_ch: one channel (sync + FSM + counters), with per-instance parameter RPT_EN.
- btn_conditioner instantiates NUM_BTN copies in a generate loop.

Test Plan:
(All scenarios use DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8, NUM_BTN=3, RPT_MASK=3'b011.)
- Clean press: btn_in[0] 0→1 sampled at E0, held → btn_level[0] = 1 and btn_press[0] = btn_step[0] = 1 for exactly one cycle at E0+6. No pulse on other channels.
- Bounce: btn_in[1] high 3 cycles, low 1, high 3, low → no btn_press/btn_level change. Then hold high 10 cycles → exactly one press pulse.
- Auto-repeat: hold btn_in[0] from E0 → btn_step[0] pulses at E0+6, E0+26, E0+34, E0+42. Release at E1 → btn_release[0] at E1+6; no btn_step after E1+6.
- Repeat disabled: hold btn_in[2] 60 cycles → exactly one btn_step[2] (coincident with btn_press[2]).
- Release glitch: while HELD, 2-cycle low dropout on btn_in[0] → no btn_release; btn_level stays 1; repeat cadence unchanged.
- Reset mid-hold: assert rst for 3 cycles while btn_in[0] held → all outputs 0 immediately. After deassert, btn_press[0] fires exactly once, 6 cycles after the first post-reset sample.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner.
// Holds the per-channel FSM state encoding, the default timing constants
// for a 100 MHz clk, and a small helper used to size the repeat counter.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_NUM_BTN    = 3;
  localparam int unsigned DEF_DB_CYCLES  = 1000000;   // 10 ms
  localparam int unsigned DEF_RPT_DELAY  = 50000000;  // 0.5 s
  localparam int unsigned DEF_RPT_PERIOD = 10000000;  // 0.1 s

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the pads and the game controller.
//   btn_in      : raw pushbutton pins (asynchronous to clk)
//   btn_level   : debounced level
//   btn_press   : one-cycle pulse on accepted rising edge
//   btn_release : one-cycle pulse on accepted falling edge
//   btn_step    : press pulse or auto-repeat pulse
// slave is the conditioner side, master is the pad/consumer side.
interface btn_conditioner_if #(
  parameter int unsigned NUM_BTN = 3
);
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_step;

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_step
  );

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_step
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, auto-repeat timer.
// Ports: clk, rst (async, active-high), pin (raw button), level/press/rel/step
// (registered outputs).
//
// state        | meaning
// IDLE         | level 0, input stable low
// PRESS_WAIT   | s2 high, counting stable samples toward acceptance
// HELD         | level 1, input stable high
// RELEASE_WAIT | s2 low, counting stable samples toward release
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
  parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD,
  parameter bit          RPT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic press,
  output logic rel,
  output logic step
);

  localparam int unsigned DB_W  = $clog2(DB_CYCLES);
  localparam int unsigned RPT_W = $clog2(max_u(RPT_DELAY, RPT_PERIOD) + 1);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(RPT_PERIOD - 1);

  logic [1:0]       sync_q, sync_d;
  btn_state_e       state_q, state_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             step_q, step_d;
  logic             rpt_tick;
  logic             s2;

  assign s2 = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], pin};
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    rpt_cnt_d = rpt_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    step_d    = 1'b0;
    rpt_tick  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s2) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = DB_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = HELD;
          press_d   = 1'b1;
          step_d    = 1'b1;
          level_d   = 1'b1;
          // Repeat timer counts down to the first repeat pulse.
          rpt_cnt_d = RPT_FIRST;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      HELD: begin
        rpt_tick = 1'b1;
        if (!s2) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = DB_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          // Dropout rejected: repeat cadence continues untouched.
          state_d  = HELD;
          db_cnt_d = '0;
          rpt_tick = 1'b1;
        end else if (db_cnt_q == DB_LAST) begin
          // No repeat tick on the release edge: repeat stops on entering IDLE.
          state_d = IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
          rpt_tick = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rpt_tick) begin
      if (rpt_cnt_q == '0) begin
        step_d    = RPT_EN;
        rpt_cnt_d = RPT_NEXT;
      end else begin
        rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      db_cnt_q  <= '0;
      rpt_cnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      step_q    <= step_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign step  = step_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel pushbutton conditioner for the pong top level.
// Ports: clk (100 MHz), rst (async, active-high), bus (btn_conditioner_if.slave:
// raw btn_in in; btn_level/btn_press/btn_release/btn_step out, all registered).
// RPT_MASK bit i enables auto-repeat on channel i.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned        NUM_BTN    = DEF_NUM_BTN,
  parameter int unsigned        DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned        RPT_DELAY  = DEF_RPT_DELAY,
  parameter int unsigned        RPT_PERIOD = DEF_RPT_PERIOD,
  parameter logic [NUM_BTN-1:0] RPT_MASK   = NUM_BTN'(3'b011)
) (
  input  logic               clk,
  input  logic               rst,
  btn_conditioner_if.slave   bus
);

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] press_w;
  logic [NUM_BTN-1:0] rel_w;
  logic [NUM_BTN-1:0] step_w;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD),
      .RPT_EN     (RPT_MASK[i])
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .pin   (bus.btn_in[i]),
      .level (level_w[i]),
      .press (press_w[i]),
      .rel   (rel_w[i]),
      .step  (step_w[i])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = rel_w;
  assign bus.btn_step    = step_w;

endmodule
